// File: rtl/biterror_monitor_if.sv
// -----------------------------------------------------------------------------
// biterror_monitor_if
//
// Purpose: bundles the bit-level monitor signals that run between the
// bit-timing unit / MAC and the biterror_monitor block.
//
// Signals (direction as seen by the monitor, i.e. the slave modport):
//   activ, sample, bitin, bitout, arbfield, ackslot, clr   : inputs
//   biterror, arblost, errcnt[CNT_W], err_sat, state_dbg[2] : outputs
//   errtotal[CNT_W]                                         : output, only
//                                                             with BITERR_STATS_EN
//
// Strobe semantics: there is no valid/ready pair here. "sample" is a one-cycle
// strobe; every cycle it is high while the monitor is in MONITOR is one
// compare event. The monitor never back-pressures.
//
// Optional feature macro: BITERR_STATS_EN (adds errtotal).
// -----------------------------------------------------------------------------
interface biterror_monitor_if #(
    parameter int CNT_W = 8
);
    logic             activ;
    logic             sample;
    logic             bitin;
    logic             bitout;
    logic             arbfield;
    logic             ackslot;
    logic             clr;
    logic             biterror;
    logic             arblost;
    logic [CNT_W-1:0] errcnt;
    logic             err_sat;
    logic [1:0]       state_dbg;
`ifdef BITERR_STATS_EN
    logic [CNT_W-1:0] errtotal;

    modport master (
        output activ, sample, bitin, bitout, arbfield, ackslot, clr,
        input  biterror, arblost, errcnt, err_sat, state_dbg, errtotal
    );

    modport slave (
        input  activ, sample, bitin, bitout, arbfield, ackslot, clr,
        output biterror, arblost, errcnt, err_sat, state_dbg, errtotal
    );
`else
    modport master (
        output activ, sample, bitin, bitout, arbfield, ackslot, clr,
        input  biterror, arblost, errcnt, err_sat, state_dbg
    );

    modport slave (
        input  activ, sample, bitin, bitout, arbfield, ackslot, clr,
        output biterror, arblost, errcnt, err_sat, state_dbg
    );
`endif
endinterface

// File: rtl/biterror_monitor.sv
// -----------------------------------------------------------------------------
// biterror_monitor
//
// Purpose: CAN bit monitor. On each sample strobe while transmitting it
// compares the transmitted bit (bitout) with the sampled bus bit (bitin) and
// classifies the result as arbitration loss, valid ACK, bit error or correct
// bit. Bit errors are stretched to HOLD cycles, counted while consecutive
// (saturating), and flagged once the count reaches ERR_LIMIT.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : biterror_monitor_if.slave (see interface header for signals)
//
// Parameters:
//   CNT_W     : width of errcnt (and errtotal)
//   ERR_LIMIT : errcnt value at/above which err_sat asserts
//   HOLD      : cycles biterror stays high per error (>= 1)
//
// Optional feature macro: BITERR_STATS_EN adds bus.errtotal, a saturating
// count of all bit errors since reset or clr.
//
// state_dbg encoding: 0 = IDLE, 1 = MONITOR, 2 = LOST.
// -----------------------------------------------------------------------------
module biterror_monitor #(
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 8,
    parameter int HOLD      = 1
) (
    input  logic                clock,
    input  logic                reset,
    biterror_monitor_if.slave   bus
);

    localparam int               HOLD_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RLD = HOLD_W'(HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(ERR_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_LOST    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              biterror_q, biterror_d;
    logic              arblost_q, arblost_d;
    logic [CNT_W-1:0]  errcnt_q, errcnt_d;
    logic              err_sat_q, err_sat_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
`ifdef BITERR_STATS_EN
    logic [CNT_W-1:0]  errtotal_q, errtotal_d;
`endif

    // Compare-event classification
    logic compare;
    logic mism;
    logic arb_loss;
    logic ack_ok;
    logic bit_err;
    logic bit_ok;

    always_comb begin
        compare  = (state_q == ST_MONITOR) && bus.activ && bus.sample;
        mism     = (bus.bitin != bus.bitout);
        // Recessive sent, dominant seen: in the arbitration field another
        // node won, in the ACK slot a receiver acknowledged. arbfield wins
        // if both qualifiers are (illegally) set together.
        arb_loss = compare && bus.arbfield && bus.bitout && !bus.bitin;
        ack_ok   = compare && !bus.arbfield && bus.ackslot && bus.bitout && !bus.bitin;
        bit_err  = compare && mism && !arb_loss && !ack_ok;
        bit_ok   = compare && !mism;
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        biterror_d = biterror_q;
        arblost_d  = arblost_q;
        errcnt_d   = errcnt_q;
        hold_d     = hold_q;
`ifdef BITERR_STATS_EN
        errtotal_d = errtotal_q;
`endif

        // Error counters: consecutive count resets on any good outcome.
        if (bit_err) begin
            if (errcnt_q != CNT_MAX) begin
                errcnt_d = errcnt_q + CNT_W'(1);
            end
`ifdef BITERR_STATS_EN
            if (errtotal_q != CNT_MAX) begin
                errtotal_d = errtotal_q + CNT_W'(1);
            end
`endif
        end else if (ack_ok || bit_ok) begin
            errcnt_d = '0;
        end

        if (!bus.activ) begin
            // Leaving transmission drops frame-local state; counters persist.
            state_d    = ST_IDLE;
            arblost_d  = 1'b0;
            biterror_d = 1'b0;
            hold_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_MONITOR;
                ST_MONITOR: if (arb_loss) state_d = ST_LOST;
                ST_LOST:    state_d = ST_LOST;
                default:    state_d = ST_IDLE;
            endcase

            if (arb_loss) begin
                arblost_d = 1'b1;
            end

            // hold_q counts the remaining high cycles after the current one;
            // a new error reloads it so overlapping pulses merge.
            if (bit_err) begin
                biterror_d = 1'b1;
                hold_d     = HOLD_RLD;
            end else if (hold_q != '0) begin
                biterror_d = 1'b1;
                hold_d     = hold_q - HOLD_W'(1);
            end else begin
                biterror_d = 1'b0;
            end
        end

        // clr overrides everything, including a simultaneous compare event.
        if (bus.clr) begin
            state_d    = bus.activ ? ST_MONITOR : ST_IDLE;
            errcnt_d   = '0;
            arblost_d  = 1'b0;
            biterror_d = 1'b0;
            hold_d     = '0;
`ifdef BITERR_STATS_EN
            errtotal_d = '0;
`endif
        end

        // Registered from the next count so it moves on the same edge.
        err_sat_d = (errcnt_d >= LIMIT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            biterror_q <= 1'b0;
            arblost_q  <= 1'b0;
            errcnt_q   <= '0;
            err_sat_q  <= 1'b0;
            hold_q     <= '0;
`ifdef BITERR_STATS_EN
            errtotal_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            biterror_q <= biterror_d;
            arblost_q  <= arblost_d;
            errcnt_q   <= errcnt_d;
            err_sat_q  <= err_sat_d;
            hold_q     <= hold_d;
`ifdef BITERR_STATS_EN
            errtotal_q <= errtotal_d;
`endif
        end
    end

    assign bus.biterror  = biterror_q;
    assign bus.arblost   = arblost_q;
    assign bus.errcnt    = errcnt_q;
    assign bus.err_sat   = err_sat_q;
    assign bus.state_dbg = state_q;
`ifdef BITERR_STATS_EN
    assign bus.errtotal  = errtotal_q;
`endif

endmodule

// File: tb/tb_biterror_monitor.sv
// -----------------------------------------------------------------------------
// tb_biterror_monitor
//
// Two monitors share one stimulus: u1 with HOLD=1 and u4 with HOLD=4, both
// CNT_W=8 and ERR_LIMIT=8. Directed steps in one initial block; every
// expected value is hand-computed.
// -----------------------------------------------------------------------------
module tb_biterror_monitor;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    biterror_monitor_if #(.CNT_W(8)) b1 ();
    biterror_monitor_if #(.CNT_W(8)) b4 ();

    biterror_monitor #(.CNT_W(8), .ERR_LIMIT(8), .HOLD(1)) u1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    biterror_monitor #(.CNT_W(8), .ERR_LIMIT(8), .HOLD(4)) u4 (
        .clock (clock),
        .reset (reset),
        .bus   (b4)
    );

    assign b4.activ    = b1.activ;
    assign b4.sample   = b1.sample;
    assign b4.bitin    = b1.bitin;
    assign b4.bitout   = b1.bitout;
    assign b4.arbfield = b1.arbfield;
    assign b4.ackslot  = b1.ackslot;
    assign b4.clr      = b1.clr;

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic bo, input logic bi);
        b1.sample = 1'b1;
        b1.bitout = bo;
        b1.bitin  = bi;
        tick();
        b1.sample = 1'b0;
        b1.bitout = 1'b1;
        b1.bitin  = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        b1.activ    = 1'b0;
        b1.sample   = 1'b0;
        b1.bitin    = 1'b1;
        b1.bitout   = 1'b1;
        b1.arbfield = 1'b0;
        b1.ackslot  = 1'b0;
        b1.clr      = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_biterror", b1.biterror, 0);
        check("rst_arblost",  b1.arblost,  0);
        check("rst_errcnt",   b1.errcnt,   0);
        check("rst_err_sat",  b1.err_sat,  0);
        check("rst_state",    b1.state_dbg, 0);

        reset    = 1'b1;
        b1.activ = 1'b1;
        tick();
        check("idle_to_monitor", b1.state_dbg, 1);

        // Basic error, HOLD=1: one cycle high, one edge after the strobe
        strobe(1'b0, 1'b1);
        check("basic_biterror_hi", b1.biterror, 1);
        check("basic_errcnt",      b1.errcnt,   1);
        check("basic_err_sat",     b1.err_sat,  0);
        tick();
        check("basic_biterror_lo", b1.biterror, 0);
        check("basic_errcnt_keep", b1.errcnt,   1);

        strobe(1'b1, 1'b1);
        check("good_bit_clears", b1.errcnt, 0);

        // ACK resets a count of 3 without an error
        repeat (3) strobe(1'b0, 1'b1);
        check("ack_pre_errcnt", b1.errcnt, 3);
        b1.ackslot = 1'b1;
        strobe(1'b1, 1'b0);
        b1.ackslot = 1'b0;
        check("ack_biterror", b1.biterror, 0);
        check("ack_errcnt",   b1.errcnt,   0);

        // Eight consecutive error strobes reach the limit
        for (int i = 1; i <= 8; i++) begin
            b1.sample = 1'b1;
            b1.bitout = 1'b0;
            b1.bitin  = 1'b1;
            tick();
            check($sformatf("cnt_errcnt_%0d", i), b1.errcnt, i);
            check($sformatf("cnt_err_sat_%0d", i), b1.err_sat, (i >= 8) ? 1 : 0);
        end
        check("cnt_biterror_merged", b1.biterror, 1);
        strobe(1'b1, 1'b1);
        check("cnt_good_errcnt",  b1.errcnt,  0);
        check("cnt_good_err_sat", b1.err_sat, 0);

        // 300 errors saturate an 8-bit counter at 255
        b1.sample = 1'b1;
        b1.bitout = 1'b0;
        b1.bitin  = 1'b1;
        repeat (300) tick();
        b1.sample = 1'b0;
        b1.bitout = 1'b1;
        check("sat_errcnt",  b1.errcnt,  255);
        check("sat_err_sat", b1.err_sat, 1);

        // clr beats a simultaneous error strobe
        b1.clr = 1'b1;
        strobe(1'b0, 1'b1);
        b1.clr = 1'b0;
        check("clr_biterror_u1", b1.biterror, 0);
        check("clr_biterror_u4", b4.biterror, 0);
        check("clr_errcnt",      b1.errcnt,   0);
        check("clr_err_sat",     b1.err_sat,  0);
        check("clr_arblost",     b1.arblost,  0);
        check("clr_state",       b1.state_dbg, 1);
`ifdef BITERR_STATS_EN
        check("clr_errtotal", b1.errtotal, 0);
`endif

        // Stretch, HOLD=4: errors two cycles apart merge into one pulse
        repeat (5) tick();
        check("str_idle", b4.biterror, 0);
        strobe(1'b0, 1'b1);
        check("str_e1", b4.biterror, 1);
        tick();
        check("str_gap", b4.biterror, 1);
        strobe(1'b0, 1'b1);
        check("str_e2", b4.biterror, 1);
        check("str_errcnt", b4.errcnt, 2);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("str_tail_%0d", k), b4.biterror, (k < 3) ? 1 : 0);
        end
`ifdef BITERR_STATS_EN
        check("str_errtotal", b4.errtotal, 2);
`endif

        // Arbitration loss
        b1.arbfield = 1'b1;
        strobe(1'b1, 1'b0);
        b1.arbfield = 1'b0;
        check("arb_arblost",  b1.arblost,  1);
        check("arb_biterror", b4.biterror, 0);
        check("arb_errcnt",   b1.errcnt,   2);
        check("arb_state",    b1.state_dbg, 2);
        strobe(1'b0, 1'b1);
        check("lost_no_error",  b4.biterror, 0);
        check("lost_errcnt",    b1.errcnt,   2);
        b1.activ = 1'b0;
        tick();
        check("arb_cleared",    b1.arblost,  0);
        check("arb_idle",       b1.state_dbg, 0);
        check("arb_errcnt_ret", b1.errcnt,   2);

        // activ falling cuts a running stretch, keeps counters
        b1.activ = 1'b1;
        tick();
        strobe(1'b0, 1'b1);
        check("act_err_hi", b4.biterror, 1);
        check("act_errcnt", b4.errcnt,   3);
        b1.activ = 1'b0;
        tick();
        check("act_fall_biterror", b4.biterror, 0);
        check("act_fall_errcnt",   b4.errcnt,   3);
        check("act_fall_state",    b4.state_dbg, 0);

        // Asynchronous reset mid-frame with an error pending
        b1.activ = 1'b1;
        tick();
        strobe(1'b0, 1'b1);
        check("pre_rst_biterror", b4.biterror, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_biterror", b4.biterror, 0);
        check("arst_errcnt",   b4.errcnt,   0);
        check("arst_arblost",  b4.arblost,  0);
        check("arst_err_sat",  b4.err_sat,  0);
        check("arst_state",    b4.state_dbg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
